// File: rtl/ama_riscv_mmio_periph.sv
`timescale 1ns/1ps
// ama_riscv_mmio_periph
// MMIO peripheral behind the core: UART TX serializer, UART RX deserializer
// and two 32-bit performance counters (cycles, retired instructions).
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   store_to_uart_i            1-cycle pulse: core stores to the TX register
//   mmio_uart_data_in_i [7:0]  TX byte, valid from the cycle after the store
//   load_from_uart_i           core loads the RX register (clears valid)
//   mmio_reset_cnt_i           level: holds both counters at zero
//   inst_wb_nop_or_clear_i     WB slot is a bubble, do not count it
//   serial_in_i                asynchronous UART RX line
//   serial_out_o               registered UART TX line
//   mmio_uart_data_out_o [7:0] last good received byte
//   mmio_data_out_valid_o      RX byte available
//   mmio_data_in_ready_o       TX can accept a byte
//   mmio_cycle_cnt_o [31:0]    free-running cycle counter
//   mmio_instr_cnt_o [31:0]    retired-instruction counter
//   tx_state_o, rx_state_o     FSM state for debug (0 IDLE,1 START,2 DATA,3 STOP)
//
// TX handshake: the core may store only while mmio_data_in_ready_o=1; a store
// seen while ready=0 is dropped. RX handshake: mmio_data_out_valid_o=1 means
// mmio_uart_data_out_o holds an unread byte; a load clears valid on that edge.
module ama_riscv_mmio_periph #(
  parameter int unsigned CPS = 217
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        store_to_uart_i,
  input  logic [7:0]  mmio_uart_data_in_i,
  input  logic        load_from_uart_i,
  input  logic        mmio_reset_cnt_i,
  input  logic        inst_wb_nop_or_clear_i,
  input  logic        serial_in_i,
  output logic        serial_out_o,
  output logic [7:0]  mmio_uart_data_out_o,
  output logic        mmio_data_out_valid_o,
  output logic        mmio_data_in_ready_o,
  output logic [31:0] mmio_cycle_cnt_o,
  output logic [31:0] mmio_instr_cnt_o,
  output logic [1:0]  tx_state_o,
  output logic [1:0]  rx_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CPS - 1);
  // Mid-bit sampling point: START waits half a bit before resampling.
  localparam logic [15:0] HALF_LAST = 16'((CPS / 2) - 1);

  // ---------------------------------------------------------------- TX
  uart_state_e tx_state_q;
  logic [15:0] tx_baud_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        serial_out_q;
  logic        store_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q   <= ST_IDLE;
      tx_baud_q    <= 16'd0;
      tx_bit_q     <= 3'd0;
      tx_shift_q   <= 8'd0;
      serial_out_q <= 1'b1;
      store_q      <= 1'b0;
    end else begin
      // The byte arrives one cycle after the strobe, so act on the delayed strobe.
      store_q <= store_to_uart_i;
      case (tx_state_q)
        ST_IDLE: begin
          if (store_q) begin
            tx_shift_q   <= mmio_uart_data_in_i;
            tx_baud_q    <= BAUD_LAST;
            serial_out_q <= 1'b0;
            tx_state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (tx_baud_q == 16'd0) begin
            tx_baud_q    <= BAUD_LAST;
            tx_bit_q     <= 3'd0;
            serial_out_q <= tx_shift_q[0];
            tx_state_q   <= ST_DATA;
          end else begin
            tx_baud_q <= tx_baud_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_baud_q == 16'd0) begin
            tx_baud_q <= BAUD_LAST;
            if (tx_bit_q == 3'd7) begin
              serial_out_q <= 1'b1;
              tx_state_q   <= ST_STOP;
            end else begin
              tx_bit_q     <= tx_bit_q + 3'd1;
              tx_shift_q   <= tx_shift_q >> 1;
              // Present the next bit on the same edge the shift happens.
              serial_out_q <= tx_shift_q[1];
            end
          end else begin
            tx_baud_q <= tx_baud_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_baud_q == 16'd0) begin
            tx_state_q <= ST_IDLE;
          end else begin
            tx_baud_q <= tx_baud_q - 16'd1;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  // A pending store_q means the FSM is about to leave IDLE.
  assign mmio_data_in_ready_o = (tx_state_q == ST_IDLE) && !store_q;
  assign serial_out_o         = serial_out_q;
  assign tx_state_o           = tx_state_q;

  // ---------------------------------------------------------------- RX
  uart_state_e rx_state_q;
  logic [1:0]  rx_sync_q;
  logic [15:0] rx_baud_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_s;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= ST_IDLE;
      rx_sync_q  <= 2'b11;
      rx_baud_q  <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], serial_in_i};
      // A byte completing in STOP below assigns valid later in this block,
      // so a coincident load loses to the new byte.
      if (load_from_uart_i) begin
        rx_valid_q <= 1'b0;
      end
      case (rx_state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            rx_baud_q  <= HALF_LAST;
            rx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (rx_baud_q == 16'd0) begin
            if (rx_s) begin
              rx_state_q <= ST_IDLE;   // line went back high: glitch
            end else begin
              rx_baud_q  <= BAUD_LAST;
              rx_bit_q   <= 3'd0;
              rx_state_q <= ST_DATA;
            end
          end else begin
            rx_baud_q <= rx_baud_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_baud_q == 16'd0) begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_baud_q  <= BAUD_LAST;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= ST_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_baud_q <= rx_baud_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (rx_baud_q == 16'd0) begin
            if (rx_s) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
            end
            rx_state_q <= ST_IDLE;
          end else begin
            rx_baud_q <= rx_baud_q - 16'd1;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  assign mmio_uart_data_out_o  = rx_data_q;
  assign mmio_data_out_valid_o = rx_valid_q;
  assign rx_state_o            = rx_state_q;

  // ---------------------------------------------------------------- counters
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    instr_cnt_d = inst_wb_nop_or_clear_i ? instr_cnt_q : instr_cnt_q + 32'd1;
    if (mmio_reset_cnt_i) begin
      cycle_cnt_d = 32'd0;
      instr_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign mmio_cycle_cnt_o = cycle_cnt_q;
  assign mmio_instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_ama_riscv_mmio_periph.sv
`timescale 1ns/1ps
// Testbench for ama_riscv_mmio_periph with CPS=8.
module tb_ama_riscv_mmio_periph;
  localparam int CPS   = 8;
  localparam int FRAME = 10 * CPS;
  // Edge index (from the first start-bit edge) on which a received byte is
  // written: 2 synchronizer edges, half a bit to mid-start, then 9 more bits.
  localparam int RX_DONE_K = 2 + CPS / 2 + 9 * CPS;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        store_to_uart = 1'b0;
  logic [7:0]  mmio_uart_data_in = 8'h00;
  logic        load_from_uart = 1'b0;
  logic        mmio_reset_cnt = 1'b0;
  logic        inst_wb_nop_or_clear = 1'b0;
  logic        serial_in = 1'b1;
  logic        serial_out;
  logic [7:0]  mmio_uart_data_out;
  logic        mmio_data_out_valid;
  logic        mmio_data_in_ready;
  logic [31:0] mmio_cycle_cnt;
  logic [31:0] mmio_instr_cnt;
  logic [1:0]  tx_state;
  logic [1:0]  rx_state;

  ama_riscv_mmio_periph #(.CPS(CPS)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .store_to_uart_i        (store_to_uart),
    .mmio_uart_data_in_i    (mmio_uart_data_in),
    .load_from_uart_i       (load_from_uart),
    .mmio_reset_cnt_i       (mmio_reset_cnt),
    .inst_wb_nop_or_clear_i (inst_wb_nop_or_clear),
    .serial_in_i            (serial_in),
    .serial_out_o           (serial_out),
    .mmio_uart_data_out_o   (mmio_uart_data_out),
    .mmio_data_out_valid_o  (mmio_data_out_valid),
    .mmio_data_in_ready_o   (mmio_data_in_ready),
    .mmio_cycle_cnt_o       (mmio_cycle_cnt),
    .mmio_instr_cnt_o       (mmio_instr_cnt),
    .tx_state_o             (tx_state),
    .rx_state_o             (rx_state)
  );

  // ------------------------------------------------------------ checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  // Counters: count cycles and non-bubble cycles, cleared by reset or reset_cnt.
  logic [31:0] exp_cycle = 32'd0;
  logic [31:0] exp_instr = 32'd0;
  bit          cnt_chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cycle <= 32'd0;
      exp_instr <= 32'd0;
    end else if (mmio_reset_cnt) begin
      exp_cycle <= 32'd0;
      exp_instr <= 32'd0;
    end else begin
      exp_cycle <= exp_cycle + 32'd1;
      exp_instr <= exp_instr + (inst_wb_nop_or_clear ? 32'd0 : 32'd1);
    end
  end

  always @(negedge clk) begin
    if (cnt_chk_en && rst_n) begin
      check_eq("cycle_cnt", mmio_cycle_cnt, exp_cycle);
      check_eq("instr_cnt", mmio_instr_cnt, exp_instr);
    end
  end

  // RX mailbox: last good byte and whether it is unread.
  logic [7:0] exp_rx_data  = 8'h00;
  logic       exp_rx_valid = 1'b0;

  // ------------------------------------------------------------ driver tasks
  // Send one byte through TX and check the line cycle by cycle against the
  // ideal frame {start=0, 8 data bits LSB first, stop=1}, CPS cycles per bit.
  // With busy_store set, a second store of b2 is issued mid-frame.
  task automatic tx_frame(input logic [7:0] b, input bit busy_store, input logic [7:0] b2);
    bit fr[10];
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = b[i];
    fr[9] = 1'b1;
    @(negedge clk);
    check_eq("tx_ready_before", mmio_data_in_ready, 1'b1);
    store_to_uart = 1'b1;
    mmio_uart_data_in = b;
    @(negedge clk);                       // past edge N+1
    store_to_uart = 1'b0;
    check_eq("tx_ready_n1", mmio_data_in_ready, 1'b0);
    check_eq("tx_line_n1", serial_out, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);                     // past edge N+2+k
      check_eq("tx_line", serial_out, fr[k / CPS]);
      check_eq("tx_ready_busy", mmio_data_in_ready, 1'b0);
      if (busy_store && k == 18) begin
        store_to_uart = 1'b1;             // store during cycle N+20
        mmio_uart_data_in = b2;
      end else if (busy_store && k == 19) begin
        store_to_uart = 1'b0;
      end
    end
    @(negedge clk);                       // past edge N+82
    check_eq("tx_ready_end", mmio_data_in_ready, 1'b1);
    check_eq("tx_line_end", serial_out, 1'b1);
    if (busy_store) begin
      for (int k = 0; k < 2 * CPS; k++) begin
        @(negedge clk);
        check_eq("tx_no_second_frame", serial_out, 1'b1);
        check_eq("tx_ready_idle", mmio_data_in_ready, 1'b1);
      end
    end
  endtask

  // Drive one frame on serial_in; load_at (edge index, -1 = none, at most
  // RX_DONE_K) raises load_from_uart for the cycle ending on that edge.
  task automatic rx_frame(input logic [7:0] b, input bit stop_bit, input int load_at);
    bit fr[10];
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = b[i];
    fr[9] = stop_bit;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      serial_in = fr[k / CPS];
      load_from_uart = (k == load_at);
    end
    @(negedge clk);
    serial_in = 1'b1;
    load_from_uart = 1'b0;
    if (load_at >= 0) exp_rx_valid = 1'b0;
    if (stop_bit) begin
      exp_rx_data  = b;
      exp_rx_valid = 1'b1;
    end
    repeat (CPS + 2) @(negedge clk);
    check_eq("rx_valid", mmio_data_out_valid, exp_rx_valid);
    check_eq("rx_data", mmio_uart_data_out, exp_rx_data);
  endtask

  task automatic rx_load();
    @(negedge clk);
    load_from_uart = 1'b1;
    @(negedge clk);
    load_from_uart = 1'b0;
    exp_rx_valid = 1'b0;
    check_eq("rx_load_valid", mmio_data_out_valid, 1'b0);
    check_eq("rx_load_data", mmio_uart_data_out, exp_rx_data);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ main sequence
  initial begin
    bit pat[5];
    logic [31:0] target;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_eq("rst_serial_out", serial_out, 1'b1);
    check_eq("rst_data_out", mmio_uart_data_out, 8'h00);
    check_eq("rst_valid", mmio_data_out_valid, 1'b0);
    check_eq("rst_ready", mmio_data_in_ready, 1'b1);
    check_eq("rst_cycle", mmio_cycle_cnt, 32'd0);
    check_eq("rst_instr", mmio_instr_cnt, 32'd0);
    rst_n = 1'b1;
    cnt_chk_en = 1'b1;

    // Counters: clear for 2 cycles, then bubble pattern 1,0,0,1,0.
    mmio_reset_cnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inst_wb_nop_or_clear = pat[i];
      @(negedge clk);
    end
    inst_wb_nop_or_clear = 1'b0;
    check_eq("cnt_cycle_5", mmio_cycle_cnt, 32'd5);
    check_eq("cnt_instr_3", mmio_instr_cnt, 32'd3);

    // Wrap of the cycle counter.
    cnt_chk_en = 1'b0;
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    check_eq("wrap_preload", mmio_cycle_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    check_eq("wrap_to_zero", mmio_cycle_cnt, 32'h0000_0000);
    mmio_reset_cnt = 1'b1;
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    cnt_chk_en = 1'b1;

    // Random counter activity.
    for (int i = 0; i < 200; i++) begin
      inst_wb_nop_or_clear = 1'($urandom_range(0, 1));
      mmio_reset_cnt = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    inst_wb_nop_or_clear = 1'b0;
    mmio_reset_cnt = 1'b0;

    // TX: 0xA5 with a dropped store mid-frame, then random bytes.
    tx_frame(8'hA5, 1'b1, 8'h3C);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);

    // RX directed cases.
    rx_frame(8'h3C, 1'b1, -1);
    rx_load();
    rx_frame(8'h81, 1'b1, RX_DONE_K);   // load coincides with completion
    rx_load();
    rx_load();                          // load with valid=0
    // Glitch: low for 3 cycles only.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    @(negedge clk);
    serial_in = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("glitch_rx_idle", rx_state, 2'd0);
    check_eq("glitch_valid", mmio_data_out_valid, exp_rx_valid);
    check_eq("glitch_data", mmio_uart_data_out, exp_rx_data);
    rx_frame(8'h55, 1'b0, -1);          // framing error
    // Overrun: two bytes without a load.
    rx_frame(8'($urandom_range(0, 255)), 1'b1, -1);
    rx_frame(8'($urandom_range(0, 255)), 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      rx_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RX_DONE_K)) : -1);
    end
    rx_frame(8'h5A, 1'b1, -1);          // leave a byte pending

    // Asynchronous reset mid-TX-frame with counters at 0x1234.
    mmio_reset_cnt = 1'b1;
    @(negedge clk);
    mmio_reset_cnt = 1'b0;
    target = 32'h1234 - 32'd30;
    for (int i = 0; i < 6000 && exp_cycle != target; i++) @(negedge clk);
    store_to_uart = 1'b1;
    mmio_uart_data_in = 8'h00;
    @(negedge clk);
    store_to_uart = 1'b0;
    target = 32'h1234;
    for (int i = 0; i < 100 && exp_cycle != target; i++) @(negedge clk);
    check_eq("pre_rst_cycle", mmio_cycle_cnt, 32'h1234);
    check_eq("pre_rst_line", serial_out, 1'b0);
    check_eq("pre_rst_ready", mmio_data_in_ready, 1'b0);
    check_eq("pre_rst_valid", mmio_data_out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_serial_out", serial_out, 1'b1);
    check_eq("arst_ready", mmio_data_in_ready, 1'b1);
    check_eq("arst_valid", mmio_data_out_valid, 1'b0);
    check_eq("arst_data", mmio_uart_data_out, 8'h00);
    check_eq("arst_cycle", mmio_cycle_cnt, 32'd0);
    check_eq("arst_instr", mmio_instr_cnt, 32'd0);
    exp_rx_data  = 8'h00;
    exp_rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rx_frame(8'($urandom_range(0, 255)), 1'b1, -1);
    tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_mmio_periph.md
Name: ama_riscv_mmio_periph

Overview:
Peripheral block directly downstream of the core's MMIO port. It consumes the core's UART store/load strobes, UART TX byte, counter-reset flag and retired-NOP flag. It produces the UART RX byte, UART status bits, and the cycle and instruction counters read back over MMIO. It contains a UART TX serializer, a UART RX deserializer, and two 32-bit performance counters.

Parameters:
CPS, 217, clock cycles per UART bit (25 MHz / 115200); legal range 4 to 65535.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
store_to_uart  in  1  EXE-stage store to the UART TX register; single-cycle pulse
mmio_uart_data_in  in  8  TX byte; valid from the cycle after store_to_uart
load_from_uart  in  1  EXE-stage load from the UART RX register
mmio_reset_cnt  in  1  level; holds both counters at 0 while high
inst_wb_nop_or_clear  in  1  WB-stage slot is a HW NOP or cleared; do not count
serial_in  in  1  UART RX line, asynchronous
serial_out  out  1  UART TX line, registered
mmio_uart_data_out  out  8  last received byte
mmio_data_out_valid  out  1  RX byte available
mmio_data_in_ready  out  1  TX can accept a byte
mmio_cycle_cnt  out  32  cycle counter
mmio_instr_cnt  out  32  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; all flops are cleared on assertion.
- Reset values:
  - serial_out=1, mmio_uart_data_out=0x00, mmio_data_out_valid=0, mmio_data_in_ready=1, both counters=0.
  - TX and RX FSMs in IDLE; RX synchronizer flops=1.
- TX handshake:
  - store_to_uart is registered into store_q.
  - On a cycle with store_q=1 and TX FSM in IDLE, latch mmio_uart_data_in into the shift register and go to START.
  - mmio_data_in_ready = (tx_state==IDLE) && !store_q. It is combinational from flops.
  - A store_to_uart pulse seen while ready=0 is dropped silently; software polls ready.
- TX FSM: IDLE -> START (serial_out=0, CPS cycles) -> DATA (8 bits LSB first, CPS cycles each) -> STOP (serial_out=1, CPS cycles) -> IDLE.
  - Frame length is 10*CPS cycles.
  - The bit counter is 3 bits; the baud counter is 16 bits, counting CPS-1 down to 0.
- RX path:
  - serial_in passes through a 2-flop synchronizer.
  - RX FSM IDLE: a synchronized 0 enters START.
  - START: wait CPS/2 cycles (integer division), then resample. If 1, the start bit is a glitch: return to IDLE. If 0, go to DATA.
  - DATA: sample every CPS cycles, LSB first, 8 bits, then go to STOP.
  - STOP: after CPS cycles, sample the line.
    - If 1: write the byte to mmio_uart_data_out and set valid=1 on the same edge.
    - If 0: framing error; discard the byte and leave valid and data unchanged.
  - RX always returns to IDLE after STOP.
- RX valid clear and overrun:
  - valid clears on the clock edge where load_from_uart=1. The core samples the pre-edge data on that edge.
  - If a byte completes on the same edge as load_from_uart, the new byte wins: data is updated and valid stays 1.
  - Overrun (a new byte while valid=1) overwrites the data; valid stays 1.
  - load_from_uart with valid=0 has no effect.
- Counters:
  - mmio_cycle_cnt increments by 1 every cycle.
  - mmio_instr_cnt increments by 1 on each cycle with inst_wb_nop_or_clear=0.
  - mmio_reset_cnt=1 forces both counters to 0 synchronously; this has priority over incrementing.
  - Both counters wrap from 0xFFFFFFFF to 0 with no flag.
- Reset mid-frame: both FSMs abort immediately; serial_out returns to 1 asynchronously.
  - A partially received byte is lost.
  - After rst_n deasserts, RX does not re-enter START until it sees a fresh 0 on serial_in.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-TX-frame while counters=0x1234.
  - Response: serial_out=1, ready=1, valid=0 and both counters=0 while rst_n is low (no clock edge required).
- TX 0xA5, CPS=8:
  - Stimulus: store_to_uart pulse at cycle N; data_in=0xA5 from N+1.
  - Response: ready=0 from N+1; serial_out=0 from edge N+2 for 8 cycles; then bits 1,0,1,0,0,1,0,1 for 8 cycles each; then stop=1 for 8 cycles; ready=1 at N+82.
- TX while busy:
  - Stimulus: a second store 0x3C at N+20, during the 0xA5 frame.
  - Response: dropped; exactly one 80-cycle frame observed; ready stays 0 until the frame ends.
- RX 0x3C, CPS=8:
  - Stimulus: drive a 0x3C frame on serial_in.
  - Response: valid=1 and data_out=0x3C after the stop sample.
  - Follow-up: load_from_uart pulse -> valid=0 on the next edge.
  - Coincidence: a second byte 0x81 completing on the same edge as load_from_uart -> valid stays 1, data=0x81.
- RX error cases:
  - Stimulus: serial_in low for 3 cycles, then high (glitch). Response: no byte, FSM back in IDLE.
  - Stimulus: frame 0x55 with stop bit=0. Response: valid stays 0, data_out unchanged.
- Counters:
  - Stimulus: mmio_reset_cnt=1 for 2 cycles, then 0; inst_wb_nop_or_clear toggles 1,0,0,1,0 over the next 5 cycles.
  - Response: cycle_cnt=5 and instr_cnt=3 after those 5 cycles.
  - Wrap: preload cycle_cnt to 0xFFFFFFFF via force -> next value is 0x00000000.
